// File: rtl/sram_arbiter.sv
// sram_arbiter: zero-fills a single-port SRAM after reset, then round-robin arbitrates two requesters with bounded bursts (SRAM_ARB_RSP_REG_EN registers read data)
module sram_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8,
  parameter int MAX_BURST = 4,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_we,
  input  logic [1:0]          req_lock,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  input  logic [2*DATA_W-1:0] req_wmask,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                init_done,
  output logic                sram_cen,
  output logic                sram_gwen,
  output logic [DATA_W-1:0]   sram_wen,
  output logic [ADDR_W-1:0]   sram_a,
  output logic [DATA_W-1:0]   sram_d,
  input  logic [DATA_W-1:0]   sram_q
);
  typedef enum logic {CLEAR, RUN} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
  state_t state, state_d;
  logic [ADDR_W-1:0] clr_cnt;
  logic last_grant, prev_lock, burst_hold, gi, any, we, clearing;
  logic [3:0] burst_cnt;
  logic [1:0] grant, rd_pend;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, wmask;
  assign burst_hold = prev_lock && req_valid[last_grant] && (burst_cnt < 4'(MAX_BURST));
  assign clearing = rst_n && (state == CLEAR);
  // grant selection, selected request fields and SRAM pin encoding
  always_comb begin
    state_d = (state == CLEAR && clr_cnt == '1) ? RUN : state;
    grant = !init_done ? 2'b00 : burst_hold ? (2'b01 << last_grant) : (&req_valid) ? (2'b10 >> last_grant) : req_valid;
    gi = grant[1];
    any = |grant;
    we = req_we[gi];
    addr = gi ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
    wdata = gi ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
    wmask = gi ? req_wmask[DATA_W +: DATA_W] : req_wmask[0 +: DATA_W];
    sram_cen = !(clearing || any);
    sram_gwen = !(clearing || (any && we));
    sram_wen = clearing ? '0 : (any && we) ? ~wmask : '1;
    sram_a = clearing ? clr_cnt : any ? addr : '0;
    sram_d = clearing ? CLEAR_VALUE : (any && we) ? wdata : '0;
  end
  assign req_ready = grant;
  // state, clear counter, arbitration history and pending-read tags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_STATE;
      clr_cnt <= '0;
      init_done <= 1'b0;
      last_grant <= 1'b1;
      prev_lock <= 1'b0;
      burst_cnt <= '0;
      rd_pend <= '0;
    end else begin
      state <= state_d;
      clr_cnt <= (state == CLEAR) ? clr_cnt + ADDR_W'(1) : '0;
      init_done <= (state_d == RUN);
      if (any) last_grant <= gi;
      prev_lock <= any && req_lock[gi];
      burst_cnt <= (any && gi == last_grant && prev_lock) ? ((burst_cnt == 4'd15) ? 4'd15 : burst_cnt + 4'd1) : 4'd1;
      rd_pend <= grant & ~req_we;
    end
  end
`ifdef SRAM_ARB_RSP_REG_EN
  logic [1:0] rsp_valid_q;
  logic [DATA_W-1:0] rdata_q;
  // capture macro output one cycle after the access, present it a cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rdata_q <= '0;
    end else begin
      rsp_valid_q <= rd_pend;
      if (|rd_pend) rdata_q <= sram_q;
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
`else
  assign rsp_valid = rd_pend;
  assign rsp_rdata = sram_q;
`endif
endmodule
